// File: rtl/wburst_sequencer_pkg.sv
// Shared state encoding and nibble constants for the DDR3 write-burst sequencer.
package wburst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } state_e;

    localparam logic [3:0] DQS_TOGGLE = 4'b0101;
    localparam logic [3:0] NIB_HIZ    = 4'b1111;
    localparam logic [3:0] NIB_DRV    = 4'b0000;
    localparam logic [3:0] NIB_ZERO   = 4'b0000;

endpackage

// File: rtl/wburst_sequencer_if.sv
// Command, FWFT data and serializer nibble bundle of one DDR3 write byte lane.
interface wburst_sequencer_if #(
    parameter int DQ_WIDTH = 8,
    parameter int LEN_BITS = 6
);

    logic                    cmd_valid;
    logic [LEN_BITS-1:0]     cmd_len;
    logic                    cmd_ready;
    logic                    data_rd;
    logic [4*DQ_WIDTH-1:0]   data_in;
    logic [3:0]              dm_in;
    logic [4*DQ_WIDTH-1:0]   dq_din;
    logic [3:0]              dq_tin;
    logic [3:0]              dm_din;
    logic [3:0]              dqs_din;
    logic [3:0]              dqs_tin;
    logic                    busy;

    modport slave (
        input  cmd_valid, cmd_len, data_in, dm_in,
        output cmd_ready, data_rd, dq_din, dq_tin, dm_din, dqs_din, dqs_tin, busy
    );

    modport master (
        output cmd_valid, cmd_len, data_in, dm_in,
        input  cmd_ready, data_rd, dq_din, dq_tin, dm_din, dqs_din, dqs_tin, busy
    );

endinterface

// File: rtl/wburst_sequencer.sv
// Write-burst sequencer: turns burst commands into DQS/DQ/DM nibble streams for
// 4:1 serializers, chaining back-to-back bursts without a DQS gap.
module wburst_sequencer
    import wburst_sequencer_pkg::*;
#(
    parameter int DQ_WIDTH = 8,
    parameter int LEN_BITS = 6
) (
    input  logic             clk_div,
    input  logic             rst,
    wburst_sequencer_if.slave bus
);

    localparam int DW = 4 * DQ_WIDTH;

    state_e              state_q, state_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic                cmd_ready, data_rd, accept, last_beat;

    logic [3:0]          dqs_tin_q, dqs_din_q, dq_tin_q, dm_din_q;
    logic [DW-1:0]       dq_din_q;

    // A zero length is run as a single-cycle burst.
    function automatic logic [LEN_BITS-1:0] len_to_cnt(input logic [LEN_BITS-1:0] len);
        return (len == '0) ? '0 : len - LEN_BITS'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        data_rd   = 1'b0;
        accept    = 1'b0;
        last_beat = (cnt_q == '0);

        unique case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_PRE: begin
                data_rd = 1'b1;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!last_beat) begin
                    data_rd = 1'b1;
                    cnt_d   = cnt_q - LEN_BITS'(1);
                end else begin
                    cmd_ready = 1'b1;
                    state_d   = ST_POST;
                end
            end
            ST_POST: begin
                cmd_ready = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase

        if (rst) begin
            cmd_ready = 1'b0;
            data_rd   = 1'b0;
        end

        // From DATA or POST the DQS low phase already exists, so the next burst skips PRE.
        accept = bus.cmd_valid && cmd_ready;
        if (accept) begin
            cnt_d = len_to_cnt(bus.cmd_len);
            if (state_q == ST_IDLE) begin
                state_d = ST_PRE;
            end else begin
                state_d = ST_DATA;
                data_rd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Nibbles are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            dqs_tin_q <= NIB_HIZ;
            dqs_din_q <= NIB_ZERO;
            dq_tin_q  <= NIB_HIZ;
            dq_din_q  <= '0;
            dm_din_q  <= NIB_ZERO;
        end else begin
            dqs_tin_q <= (state_d == ST_IDLE) ? NIB_HIZ : NIB_DRV;
            dqs_din_q <= (state_d == ST_DATA) ? DQS_TOGGLE : NIB_ZERO;
            dq_tin_q  <= (state_d == ST_DATA) ? NIB_DRV : NIB_HIZ;
            dq_din_q  <= data_rd ? bus.data_in : '0;
            dm_din_q  <= data_rd ? bus.dm_in : NIB_ZERO;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.data_rd   = data_rd;
    assign bus.dqs_tin   = dqs_tin_q;
    assign bus.dqs_din   = dqs_din_q;
    assign bus.dq_tin    = dq_tin_q;
    assign bus.dq_din    = dq_din_q;
    assign bus.dm_din    = dm_din_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wburst_sequencer.sv
// Bench for wburst_sequencer: a per-cycle timeline model of burst phases plus an
// FWFT queue predicts every output; randomized and directed scenarios.
module tb_wburst_sequencer;

    localparam int DQ_WIDTH = 8;
    localparam int LEN_BITS = 6;
    localparam int DW       = 4 * DQ_WIDTH;
    localparam int VW       = 3 + 12 + 4 + DW;
    localparam int MAXC     = 4096;

    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_PRE  = 2'd1;
    localparam logic [1:0] K_DATA = 2'd2;
    localparam logic [1:0] K_POST = 2'd3;

    logic clk_div = 1'b0;
    logic rst     = 1'b1;

    wburst_sequencer_if #(.DQ_WIDTH(DQ_WIDTH), .LEN_BITS(LEN_BITS)) bus ();

    wburst_sequencer #(.DQ_WIDTH(DQ_WIDTH), .LEN_BITS(LEN_BITS)) dut (
        .clk_div (clk_div),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_div = ~clk_div;

    // kind[n] is the phase the lane must show in cycle n.
    logic [1:0]    kind [MAXC];
    int            cyc;
    int            last_data;
    int            tests;
    int            fails;
    logic [DW+3:0] wq[$];
    logic [DW+3:0] eq[$];

    task automatic model_clear();
        for (int p = cyc; p < MAXC; p++) kind[p] = K_IDLE;
        last_data = -1;
        wq.delete();
        eq.delete();
    endtask

    task automatic flush_words();
        wq.delete();
        eq.delete();
    endtask

    task automatic push_word(input logic [DW+3:0] w);
        wq.push_back(w);
        eq.push_back(w);
    endtask

    function automatic logic [VW-1:0] observe();
        return {bus.busy, bus.cmd_ready, bus.data_rd, bus.dqs_tin, bus.dqs_din,
                bus.dq_tin, bus.dm_din, bus.dq_din};
    endfunction

    // One clk_div cycle: drive, predict, sample, advance.
    task automatic tick(input logic v, input logic [LEN_BITS-1:0] len, output logic acc,
                        output logic [VW-1:0] exp_o, output logic [VW-1:0] obs_o);
        logic [1:0]    k;
        logic          rdy;
        logic          rd;
        int            n;
        logic [DW+3:0] w;
        logic [DW+3:0] dropped;
        while (wq.size() < 8) push_word({4'($urandom_range(15)), DW'($urandom)});
        bus.cmd_valid = v;
        bus.cmd_len   = len;
        {bus.dm_in, bus.data_in} = wq[0];
        #3;
        k   = kind[cyc];
        rdy = (k == K_IDLE) || (k == K_POST) || (k == K_DATA && last_data == cyc);
        acc = v && rdy;
        n   = (len == '0) ? 1 : int'(len);
        if (acc) begin
            if (k == K_IDLE) begin
                kind[cyc+1] = K_PRE;
                for (int p = cyc + 2; p <= cyc + 1 + n; p++) kind[p] = K_DATA;
                last_data = cyc + 1 + n;
            end else begin
                for (int p = cyc + 1; p <= cyc + n; p++) kind[p] = K_DATA;
                last_data = cyc + n;
            end
            kind[last_data+1] = K_POST;
        end
        rd = (kind[cyc+1] == K_DATA);
        w  = '0;
        if (k == K_DATA && eq.size() > 0) w = eq.pop_front();
        exp_o = {k != K_IDLE, rdy, rd,
                 (k == K_IDLE) ? 4'hF : 4'h0,
                 (k == K_DATA) ? 4'h5 : 4'h0,
                 (k == K_DATA) ? 4'h0 : 4'hF,
                 w};
        obs_o = observe();
        if (bus.data_rd === 1'b1 && wq.size() > 0) dropped = wq.pop_front();
        @(posedge clk_div);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic          acc;
        logic [VW-1:0] e, o;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.data_in   = '0;
        bus.dm_in     = '0;
        repeat (2) @(posedge clk_div);
        #1;
        o = observe();
        tests++;
        if (o !== {3'b000, 4'hF, 4'h0, 4'hF, 4'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_hold got=%h exp=%h", o, {3'b000, 4'hF, 4'h0, 4'hF, 4'h0, 32'h0});
        end
        rst = 1'b0;
        cyc = 0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0, acc, e, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
    endtask

    task automatic test_single();
        logic          acc;
        logic          pend;
        logic [VW-1:0] e, o;
        logic [VW-1:0] hist [8];
        int            rdcnt;
        flush_words();
        push_word({4'h0, 32'hA5A5_A5A5});
        push_word({4'h3, 32'h3C3C_3C3C});
        pend  = 1'b1;
        rdcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(pend, 6'd2, acc, e, o);
            if (acc) pend = 1'b0;
            hist[i] = o;
            rdcnt += int'(o[DW+4+12]);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        tests++;
        if (rdcnt !== 2) begin
            fails++;
            $display("FAIL single_rd_pulses got=%0d exp=2", rdcnt);
        end
        tests++;
        if (hist[2][DW-1:0] !== 32'hA5A5_A5A5 || hist[3][DW-1:0] !== 32'h3C3C_3C3C) begin
            fails++;
            $display("FAIL single_words got=%h,%h exp=a5a5a5a5,3c3c3c3c", hist[2][DW-1:0], hist[3][DW-1:0]);
        end
        tests++;
        if (hist[1][DW+11:DW+4] !== 8'h0F || hist[4][DW+11:DW+4] !== 8'h0F || hist[5][VW-1] !== 1'b0) begin
            fails++;
            $display("FAIL single_pre_post got=%h,%h,%b exp=0f,0f,0", hist[1][DW+11:DW+4],
                     hist[4][DW+11:DW+4], hist[5][VW-1]);
        end
    endtask

    task automatic test_back_to_back();
        logic          acc;
        logic [VW-1:0] e, o;
        int            stage, first, last, ndata, rdcnt, gaps;
        flush_words();
        stage = 0; first = -1; last = -1; ndata = 0; rdcnt = 0; gaps = 0;
        for (int i = 0; i < 12; i++) begin
            tick(stage < 2, (stage == 0) ? 6'd2 : 6'd3, acc, e, o);
            if (acc) stage++;
            if (o[DW+11:DW+8] == 4'h5) begin
                if (first < 0) first = i;
                last = i;
                ndata++;
            end
            rdcnt += int'(o[DW+4+12]);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL chain cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        tests++;
        if (ndata !== 5 || last - first !== 4 || rdcnt !== 5) begin
            fails++;
            $display("FAIL chain_contig got data=%0d span=%0d rd=%0d exp data=5 span=4 rd=5",
                     ndata, last - first, rdcnt);
        end
    endtask

    task automatic test_post_cmd();
        logic          acc;
        logic [VW-1:0] e, o;
        logic [VW-1:0] hist [10];
        int            stage, a2, rdcnt;
        flush_words();
        stage = 0; a2 = 0; rdcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick((stage == 0) || (stage == 1 && kind[cyc] == K_POST), 6'd1, acc, e, o);
            if (acc) begin
                stage++;
                if (stage == 2) a2 = i;
            end
            hist[i] = o;
            rdcnt += int'(o[DW+4+12]);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL post_cmd cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        tests++;
        if (a2 == 0 || hist[a2][DW+15:DW+4] !== 12'h00F || hist[a2+1][DW+11:DW+8] !== 4'h5 ||
            hist[a2+1][VW-1] !== 1'b1 || rdcnt !== 2) begin
            fails++;
            $display("FAIL post_to_data got acc_at=%0d nibs=%h next_dqs=%h rd=%0d exp nibs=00f next_dqs=5 rd=2",
                     a2, hist[a2][DW+15:DW+4], hist[a2+1][DW+11:DW+8], rdcnt);
        end
    endtask

    task automatic test_len_zero();
        logic          acc;
        logic          pend;
        logic [VW-1:0] e, o;
        int            ndata, rdcnt;
        flush_words();
        pend = 1'b1; ndata = 0; rdcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(pend, 6'd0, acc, e, o);
            if (acc) pend = 1'b0;
            ndata += (o[DW+11:DW+8] == 4'h5) ? 1 : 0;
            rdcnt += int'(o[DW+4+12]);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL len_zero cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        tests++;
        if (ndata !== 1 || rdcnt !== 1) begin
            fails++;
            $display("FAIL len_zero_count got data=%0d rd=%0d exp data=1 rd=1", ndata, rdcnt);
        end
    endtask

    task automatic test_reset_mid();
        logic          acc;
        logic [VW-1:0] e, o;
        flush_words();
        tick(1'b1, 6'd4, acc, e, o);
        tick(1'b0, 6'd0, acc, e, o);
        tick(1'b0, 6'd0, acc, e, o);
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL mid_first_data cyc=%0d got=%h exp=%h", cyc, o, e);
        end
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        #3;
        tests++;
        if ({bus.cmd_ready, bus.data_rd} !== 2'b00 || bus.dqs_din !== 4'h5) begin
            fails++;
            $display("FAIL mid_rst_cycle got ready/rd=%b dqs=%h exp 00 and 5",
                     {bus.cmd_ready, bus.data_rd}, bus.dqs_din);
        end
        @(posedge clk_div);
        #1;
        cyc++;
        model_clear();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, acc, e, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL mid_after_rst cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        for (int i = 0; i < 7; i++) begin
            tick(i == 0, 6'd2, acc, e, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL mid_restart cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
    endtask

    task automatic test_random();
        logic                acc;
        logic                pend;
        logic [LEN_BITS-1:0] len;
        logic [VW-1:0]       e, o;
        flush_words();
        pend = 1'b0;
        len  = '0;
        for (int i = 0; i < 420; i++) begin
            if (!pend && i < 400 && $urandom_range(2) == 0) begin
                pend = 1'b1;
                len  = LEN_BITS'($urandom_range(5));
            end
            tick(pend, len, acc, e, o);
            if (acc) pend = 1'b0;
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_post_cmd();
        test_len_zero();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
